serial_addsub: RTL and testbench
================================

Name: serial_addsub

Overview:
- Bit-serial, parametrised adder/subtractor built around a one-bit full add/subtract cell.
- Latches two WIDTH-bit operands on a start pulse, processes one bit per clock LSB-first, then reports result, carry/borrow-out and signed overflow.
- Uses a start/busy/done handshake, so the block sits behind a simple controller in the digital-circuits lab datapath.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 1..32).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived; not overridden by users).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when the block is idle or done.
- op_sub  input  1  0 = add (a+b+cin), 1 = subtract (a-b-cin); latched at start.
- a  input  WIDTH  operand A; latched at start.
- b  input  WIDTH  operand B; latched at start.
- cin  input  1  carry-in (add) or borrow-in (sub); latched at start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when the result is valid.
- result  output  WIDTH  sum or difference; held until the next accepted start.
- cout  output  1  carry-out (add) or borrow-out (sub) of the MSB.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset, when rst is high at a clock edge:
  - State goes to IDLE.
  - busy=0, done=0, result=0, cout=0, ovf=0, counter=0.
  - Reset has priority over everything, including mid-operation; a partial result is discarded.
- States are IDLE, RUN and DONE.
- IDLE:
  - If start=1 at an edge, latch a, b, op_sub and cin into shift registers, load the carry/borrow flop with cin, set counter=0 and go to RUN.
  - busy rises in the cycle after that edge.
- RUN:
  - Each edge feeds bit 0 of the A and B shift registers plus the carry flop into the cell.
  - The cell output bit is shifted into result at the MSB, so result is right-shifted each edge.
  - The cell's carry/borrow-out updates the carry flop, and counter increments.
  - At the edge where counter reaches WIDTH-1 (the final bit), go to DONE.
  - start is ignored in RUN; no queueing.
- Cell equations:
  - Output bit = a^b^c.
  - Add carry-out = (a&b) | (c&(a^b)).
  - Subtract borrow-out = (~a&b) | (c&~(a^b)).
- DONE:
  - done=1 and busy=0 for exactly one cycle; result and cout are final.
  - ovf in add mode = (a_msb==b_msb) && (r_msb!=a_msb).
  - ovf in subtract mode = (a_msb!=b_msb) && (r_msb!=a_msb), using latched operand MSBs.
  - Next edge goes to IDLE; a start sampled at that edge is accepted exactly as in IDLE.
- Latency:
  - Start accepted at edge E0; busy is high for cycles E0..E(WIDTH-1).
  - done is high in the cycle following edge E(WIDTH), i.e. WIDTH cycles after acceptance.
  - Back-to-back throughput is one operation per WIDTH+1 cycles.
- Output holding: result, cout and ovf hold their values in IDLE until the next accepted start.
- During RUN, result shows partial bits and must not be consumed before done.
- WIDTH=1 degenerates to one full add/subtract per 2 cycles; its truth table must match the combinational full subtractor/adder.
- X on a, b or cin outside the accepting edge has no effect.

Decomposition:
- Shared package/include holds the state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2, plus OP_ADD=1'b0 and OP_SUB=1'b1.
- One natural sub-module: fa_fs_cell, purely combinational.
  - Ports: x, y, c, sub, out d, co.
  - Implements the cell equations above and is instantiated once.
- FSM, shift registers and counter live in serial_addsub.

Test Plan:
- WIDTH=8, sub, a=0x05, b=0x03, cin=0 -> done exactly 8 cycles after the start edge; result=0x02, cout=0, ovf=0.
- WIDTH=8, sub, a=0x03, b=0x05, cin=0 -> result=0xFE, cout=1 (borrow), ovf=0; a=0x80, b=0x01 -> result=0x7F, cout=0, ovf=1.
- WIDTH=8, add, a=0xFF, b=0x01, cin=0 -> result=0x00, cout=1, ovf=0; a=0x7F, b=0x01 -> result=0x80, ovf=1.
- WIDTH=8, start re-pulsed at cycle 3 of RUN with different operands -> ignored; original result delivered, single done pulse. Start in the DONE cycle -> new operation begins, busy the next cycle.
- rst asserted at cycle 4 of RUN -> next cycle busy=0, done=0, result=0, cout=0, ovf=0; a subsequent start computes correctly.
- WIDTH=1, sub, all 8 combinations of a, b, cin -> result/cout equal the full-subtractor truth table (e.g. 0,1,1 -> d=0, borrow=1); done each 1 cycle after start.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
// Shared encodings and helpers for the bit-serial adder/subtractor.
// The state and op codes are visible to any controller that instantiates the block.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Two's-complement overflow from operand MSBs and the final result MSB.
  function automatic logic signed_ovf(input logic sub, input logic a_msb,
                                      input logic b_msb, input logic r_msb);
    if (sub == OP_SUB)
      return (a_msb != b_msb) && (r_msb != a_msb);
    else
      return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/serial_addsub_fa_fs_cell.sv
// One-bit full adder / full subtractor cell, purely combinational.
// sub=0 gives x+y+c with carry-out; sub=1 gives x-y-c with borrow-out.
module fa_fs_cell (
  input  logic x,
  input  logic y,
  input  logic c,
  input  logic sub,
  output logic d,
  output logic co
);

  assign d  = x ^ y ^ c;
  assign co = sub ? ((~x & y) | (c & ~(x ^ y)))
                  : ((x & y)  | (c & (x ^ y)));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor with start/busy/done handshake.
// Operands are consumed LSB-first; result fills from the MSB end by right-shifting.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic             carry, sub_q, a_msb, b_msb;
  logic [CNT_W-1:0] cnt;
  logic             cell_d, cell_co;
  logic             accept, last_bit;
  logic [WIDTH:0]   res_cat;

  assign accept   = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign last_bit = (cnt == LAST_CNT);
  assign res_cat  = {cell_d, result};

  fa_fs_cell u_cell (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .c  (carry),
    .sub(sub_q),
    .d  (cell_d),
    .co (cell_co)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (last_bit) state_nxt = ST_DONE;
      ST_DONE: state_nxt = start ? ST_RUN : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      ST_RUN:  busy = 1'b1;
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Operand shift registers, carry flop, counter and result/flag capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= b;
      sub_q <= op_sub;
      carry <= cin;
      a_msb <= a[WIDTH-1];
      b_msb <= b[WIDTH-1];
      cnt   <= '0;
    end else if (state == ST_RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      result <= res_cat[WIDTH:1];
      carry  <= cell_co;
      cnt    <= cnt + CNT_W'(1);
      if (last_bit) begin
        cout <= cell_co;
        ovf  <= signed_ovf(sub_q, a_msb, b_msb, cell_d);
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub at WIDTH=8 and WIDTH=1 with an expected-result queue.
module tb_serial_addsub;

  typedef struct {
    logic [7:0] r;
    logic       co;
    logic       ov;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8, sub8, cin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] res8;
  logic       start1, sub1, cin1;
  logic [0:0] a1, b1;
  logic       busy1, done1, cout1, ovf1;
  logic [0:0] res1;

  exp_t q8[$];
  exp_t q1[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op_sub(sub8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .result(res8), .cout(cout8), .ovf(ovf8)
  );

  serial_addsub #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .op_sub(sub1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .result(res1), .cout(cout1), .ovf(ovf1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Arithmetic reference: unsigned value gives carry/borrow, signed value gives overflow.
  function automatic exp_t model(input int w, input bit sub, input int ua, input int ub,
                                 input int c);
    exp_t e;
    int   sa, sb, u, s, lim;
    lim = 1 << (w - 1);
    sa  = (ua >= lim) ? ua - 2 * lim : ua;
    sb  = (ub >= lim) ? ub - 2 * lim : ub;
    if (sub) begin
      u    = ua - ub - c;
      s    = sa - sb - c;
      e.co = (u < 0);
    end else begin
      u    = ua + ub + c;
      s    = sa + sb + c;
      e.co = (u >= 2 * lim);
    end
    e.r  = 8'(u & (2 * lim - 1));
    e.ov = (s < -lim) || (s >= lim);
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic start_op8(input bit sub, input logic [7:0] a, input logic [7:0] b,
                           input bit c, input string tag);
    start8 = 1'b1; sub8 = sub; a8 = a; b8 = b; cin8 = c;
    q8.push_back(model(8, sub, int'(a), int'(b), int'(c)));
    @(negedge clk);
    start8 = 1'b0; a8 = 'x; b8 = 'x; cin8 = 1'bx; sub8 = 1'bx;
    check({tag, "_busy"}, 32'(busy8), 32'd1);
  endtask

  task automatic wait_done8(input int lat0, input string tag);
    int   lat;
    exp_t e;
    lat = lat0;
    while (done8 !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd8);
    check({tag, "_qsize"}, 32'(q8.size()), 32'd1);
    if (q8.size() > 0) begin
      e = q8.pop_front();
      check({tag, "_result"}, 32'(res8), 32'(e.r));
      check({tag, "_cout"}, 32'(cout8), 32'(e.co));
      check({tag, "_ovf"}, 32'(ovf8), 32'(e.ov));
    end
  endtask

  task automatic after_done8(input string tag);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done8), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy8), 32'd0);
  endtask

  task automatic run_op1(input bit a, input bit b, input bit c);
    int   lat;
    exp_t e;
    start1 = 1'b1; sub1 = 1'b1; a1 = a; b1 = b; cin1 = c;
    q1.push_back(model(1, 1'b1, int'(a), int'(b), int'(c)));
    @(negedge clk);
    start1 = 1'b0; a1 = 'x; b1 = 'x; cin1 = 1'bx;
    lat = 0;
    while (done1 !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check($sformatf("w1_%0d%0d%0d_latency", a, b, c), 32'(lat), 32'd1);
    if (q1.size() > 0) begin
      e = q1.pop_front();
      check($sformatf("w1_%0d%0d%0d_d", a, b, c), 32'(res1), 32'(e.r[0]));
      check($sformatf("w1_%0d%0d%0d_borrow", a, b, c), 32'(cout1), 32'(e.co));
      check($sformatf("w1_%0d%0d%0d_ovf", a, b, c), 32'(ovf1), 32'(e.ov));
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_result", 32'(res8), 32'd0);
    check("rst_cout", 32'(cout8), 32'd0);
    check("rst_ovf", 32'(ovf8), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    start_op8(1'b1, 8'h05, 8'h03, 1'b0, "sub_5_3");
    wait_done8(0, "sub_5_3");
    after_done8("sub_5_3");
    start_op8(1'b1, 8'h03, 8'h05, 1'b0, "sub_3_5");
    wait_done8(0, "sub_3_5");
    after_done8("sub_3_5");
    start_op8(1'b1, 8'h80, 8'h01, 1'b0, "sub_80_1");
    wait_done8(0, "sub_80_1");
    after_done8("sub_80_1");
    start_op8(1'b0, 8'hFF, 8'h01, 1'b0, "add_ff_1");
    wait_done8(0, "add_ff_1");
    after_done8("add_ff_1");
    start_op8(1'b0, 8'h7F, 8'h01, 1'b0, "add_7f_1");
    wait_done8(0, "add_7f_1");
    after_done8("add_7f_1");
    start_op8(1'b0, 8'hA5, 8'h3C, 1'b1, "add_cin");
    wait_done8(0, "add_cin");
    after_done8("add_cin");
    start_op8(1'b1, 8'h40, 8'h40, 1'b1, "sub_bin");
    wait_done8(0, "sub_bin");
    after_done8("sub_bin");

    // Start re-pulsed mid-run must be ignored.
    start_op8(1'b1, 8'h05, 8'h03, 1'b0, "repulse");
    repeat (3) @(negedge clk);
    start8 = 1'b1; sub8 = 1'b0; a8 = 8'h11; b8 = 8'h22; cin8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8(4, "repulse");
    after_done8("repulse");
    repeat (10) @(negedge clk);
    check("repulse_no_run", 32'(busy8), 32'd0);

    // Start issued in the DONE cycle chains directly into a new run.
    start_op8(1'b0, 8'h10, 8'h20, 1'b0, "chain_a");
    wait_done8(0, "chain_a");
    start_op8(1'b1, 8'h20, 8'h30, 1'b1, "chain_b");
    wait_done8(0, "chain_b");
    after_done8("chain_b");

    // Reset mid-run discards the partial result.
    start_op8(1'b0, 8'h12, 8'h34, 1'b0, "midrst");
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 32'(busy8), 32'd0);
    check("midrst_done", 32'(done8), 32'd0);
    check("midrst_result", 32'(res8), 32'd0);
    check("midrst_cout", 32'(cout8), 32'd0);
    check("midrst_ovf", 32'(ovf8), 32'd0);
    q8.delete();
    repeat (10) @(negedge clk);
    check("midrst_stay_idle", 32'(done8), 32'd0);
    start_op8(1'b1, 8'h9C, 8'h27, 1'b0, "post_rst");
    wait_done8(0, "post_rst");
    after_done8("post_rst");

    for (int i = 0; i < 8; i++) run_op1(i[2], i[1], i[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
